// File: rtl/dbg_console_master.sv
// Debug console bus master: buffers characters in a small FIFO and writes each one to
// the console data register, then reports a test result word once the FIFO has drained.
module dbg_console_master #(
  parameter logic [31:0] BASE_ADDR    = 32'hE000_FFF0,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned RESP_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        char_valid,
  input  logic [7:0]  char_data,
  output logic        char_ready,
  input  logic        done_req,
  input  logic [31:0] done_code,
  output logic [31:0] m_address,
  output logic [31:0] m_writedata,
  output logic        m_write,
  output logic        m_read,
  output logic [3:0]  m_byteenable,
  output logic [4:0]  m_burstcount,
  input  logic        m_waitrequest,
  input  logic        m_writeresponsevalid,
  input  logic [1:0]  m_response,
  output logic        busy,
  output logic        done,
  output logic        err_resp,
  output logic        err_timeout
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [15:0] TimerLast = 16'(RESP_TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StCmd, StResp, StFinished} state_e;

  state_e          r_state;
  state_e          w_state_next;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic            r_pend;
  logic [31:0]     r_code;
  logic [31:0]     r_addr;
  logic [31:0]     r_data;
  logic [3:0]      r_be;
  logic            r_is_result;
  logic [15:0]     r_timer;
  logic            r_err_resp;
  logic            r_err_timeout;

  logic            w_full;
  logic            w_nonempty;
  logic            w_push;
  logic            w_pop;
  logic            w_load_char;
  logic            w_load_res;
  logic            w_complete;
  logic            w_clr_timer;
  logic            w_timeout;
  logic            w_resp_err;
  logic [7:0]      w_head;

  assign w_full     = (r_count == CW'(FIFO_DEPTH));
  assign w_nonempty = (r_count != '0);
  // char_ready is held low while reset is applied, not just once the FIFO clears.
  assign char_ready = ~rst_i & ~w_full;
  assign w_push     = char_valid & char_ready;
  assign w_head     = r_mem[r_rptr];
  // Only a response that actually arrived can flag an error; a timeout carries none.
  assign w_resp_err = w_complete & m_writeresponsevalid & (m_response != 2'b00);

  assign m_address    = r_addr;
  assign m_writedata  = r_data;
  assign m_byteenable = r_be;
  assign m_write      = (r_state == StCmd);
  assign m_read       = 1'b0;
  assign m_burstcount = 5'd1;
  assign busy         = (r_state == StCmd) || (r_state == StResp) || w_nonempty;
  assign done         = (r_state == StFinished);
  assign err_resp     = r_err_resp;
  assign err_timeout  = r_err_timeout;

  // Next-state decode and per-cycle control strobes.
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_load_char  = 1'b0;
    w_load_res   = 1'b0;
    w_complete   = 1'b0;
    w_clr_timer  = 1'b0;
    w_timeout    = 1'b0;
    unique case (r_state)
      StIdle: begin
        // Characters always win over a pending result so the report comes last.
        if (w_nonempty) begin
          w_pop        = 1'b1;
          w_load_char  = 1'b1;
          w_state_next = StCmd;
        end else if (r_pend) begin
          w_load_res   = 1'b1;
          w_state_next = StCmd;
        end
      end
      StCmd: begin
        if (!m_waitrequest) begin
          if (m_writeresponsevalid) begin
            w_complete = 1'b1;
          end else begin
            w_clr_timer  = 1'b1;
            w_state_next = StResp;
          end
        end
      end
      StResp: begin
        if (m_writeresponsevalid) begin
          w_complete = 1'b1;
        end else if (r_timer == TimerLast) begin
          w_timeout  = 1'b1;
          w_complete = 1'b1;
        end
      end
      StFinished: ;
      default: w_state_next = StIdle;
    endcase
    if (w_complete) begin
      w_state_next = r_is_result ? StFinished : StIdle;
    end
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FIFO storage; contents need no reset because count gates every read.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr] <= char_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: ;
      endcase
    end
  end

  // Latched end-of-test request; a newer request overwrites the code.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pend <= 1'b0;
      r_code <= '0;
    end else if (done_req && (r_state != StFinished)) begin
      r_pend <= 1'b1;
      r_code <= done_code;
    end else if (w_load_res) begin
      r_pend <= 1'b0;
    end
  end

  // Command registers, loaded once when leaving IDLE and held through any stall.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_addr      <= '0;
      r_data      <= '0;
      r_be        <= '0;
      r_is_result <= 1'b0;
    end else if (w_load_char) begin
      r_addr      <= BASE_ADDR;
      r_data      <= {w_head, 24'h0};
      r_be        <= 4'b1000;
      r_is_result <= 1'b0;
    end else if (w_load_res) begin
      r_addr      <= BASE_ADDR + 32'd8;
      r_data      <= {r_code[7:0], r_code[15:8], r_code[23:16], r_code[31:24]};
      r_be        <= 4'b1111;
      r_is_result <= 1'b1;
    end
  end

  // Response wait timer, counting cycles spent in RESP.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_timer <= '0;
    end else if (w_clr_timer) begin
      r_timer <= '0;
    end else if (r_state == StResp) begin
      r_timer <= r_timer + 16'd1;
    end
  end

  // Sticky error flags.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_err_resp    <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      if (w_resp_err) r_err_resp    <= 1'b1;
      if (w_timeout)  r_err_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dbg_console_master.sv
// Bench for dbg_console_master: random and directed traffic against a transaction-level model.
module tb_dbg_console_master;

  localparam logic [31:0] BASE  = 32'hE000_FFF0;
  localparam int          DEPTH = 8;
  localparam int          TO    = 4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        char_valid, done_req;
  logic [7:0]  char_data;
  logic [31:0] done_code;
  logic        char_ready;
  logic [31:0] m_address, m_writedata;
  logic        m_write, m_read;
  logic [3:0]  m_byteenable;
  logic [4:0]  m_burstcount;
  logic        m_waitrequest, m_writeresponsevalid;
  logic [1:0]  m_response;
  logic        busy, done, err_resp, err_timeout;

  always #5 clk_i = ~clk_i;

  dbg_console_master #(
    .BASE_ADDR   (BASE),
    .FIFO_DEPTH  (DEPTH),
    .RESP_TIMEOUT(TO)
  ) dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .char_valid          (char_valid),
    .char_data           (char_data),
    .char_ready          (char_ready),
    .done_req            (done_req),
    .done_code           (done_code),
    .m_address           (m_address),
    .m_writedata         (m_writedata),
    .m_write             (m_write),
    .m_read              (m_read),
    .m_byteenable        (m_byteenable),
    .m_burstcount        (m_burstcount),
    .m_waitrequest       (m_waitrequest),
    .m_writeresponsevalid(m_writeresponsevalid),
    .m_response          (m_response),
    .busy                (busy),
    .done                (done),
    .err_resp            (err_resp),
    .err_timeout         (err_timeout)
  );

  int checks = 0;
  int failures = 0;
  int mode = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] swap32(input logic [31:0] c);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[8*(3-i) +: 8] = c[8*i +: 8];
    return r;
  endfunction

  // Transaction-level model of what the master owes the bus.
  logic [7:0]  q[$];
  logic        pend = 0, txn = 0, fin = 0, in_cmd = 0, in_resp = 0;
  logic        eresp = 0, eto = 0, prev_w = 0, exp_start = 0;
  logic [31:0] pcode = 0, e_addr = 0, e_data = 0;
  logic [3:0]  e_be = 0;
  logic        e_res = 0;
  logic        h_push = 0, h_done = 0;
  logic [7:0]  h_data = 0;
  logic [31:0] h_code = 0;
  int          rcnt = 0;
  int          npush = 0;
  logic [31:0] acc_addr[$], acc_data[$];
  logic [3:0]  acc_be[$];

  // Compare process: one model step per cycle, sampled mid-cycle.
  always @(negedge clk_i) begin : mon
    logic       started;
    logic       comp;
    logic [7:0] ch;
    if (rst_i) begin
      q.delete();
      pend = 0; txn = 0; fin = 0; in_cmd = 0; in_resp = 0; eresp = 0; eto = 0;
      prev_w = 0; exp_start = 0; h_push = 0; h_done = 0;
      chk("rst_m_write", m_write, 0);
      chk("rst_m_address", m_address, 0);
      chk("rst_m_writedata", m_writedata, 0);
      chk("rst_m_byteenable", m_byteenable, 0);
      chk("rst_flags", {busy, done, err_resp, err_timeout, char_ready}, 0);
    end else begin
      // A decision taken last cycle shows up as a rising m_write now.
      started = m_write && !prev_w;
      chk("cmd_start", started, exp_start);
      if (started && exp_start) begin
        if (q.size() != 0) begin
          ch = q.pop_front();
          e_addr = BASE; e_data = {ch, 24'h0}; e_be = 4'b1000; e_res = 0;
        end else begin
          e_addr = BASE + 32'd8; e_data = swap32(pcode); e_be = 4'b1111; e_res = 1; pend = 0;
        end
        txn = 1; in_cmd = 1;
      end
      // Last cycle's push and done request become visible now.
      if (h_push) q.push_back(h_data);
      if (h_done) begin pend = 1; pcode = h_code; end

      chk("char_ready", char_ready, q.size() < DEPTH);
      chk("busy", busy, txn || (q.size() != 0));
      chk("done", done, fin);
      chk("err_resp", err_resp, eresp);
      chk("err_timeout", err_timeout, eto);
      chk("m_write", m_write, in_cmd);
      chk("m_read", m_read, 0);
      chk("m_burstcount", m_burstcount, 1);
      if (in_cmd) begin
        chk("m_address", m_address, e_addr);
        chk("m_writedata", m_writedata, e_data);
        chk("m_byteenable", m_byteenable, e_be);
      end
      exp_start = !txn && !fin && (q.size() != 0 || pend);

      h_push = char_valid && char_ready; h_data = char_data;
      h_done = done_req && !fin;         h_code = done_code;
      if (h_push) npush++;

      comp = 0;
      if (in_cmd && !m_waitrequest) begin
        acc_addr.push_back(m_address); acc_data.push_back(m_writedata);
        acc_be.push_back(m_byteenable);
        in_cmd = 0;
        if (m_writeresponsevalid) comp = 1;
        else begin in_resp = 1; rcnt = 0; end
      end else if (in_resp) begin
        if (m_writeresponsevalid) comp = 1;
        else begin
          rcnt++;
          if (rcnt == TO) begin eto = 1; comp = 1; end
        end
      end
      if (comp) begin
        if (m_writeresponsevalid && m_response != 2'b00) eresp = 1;
        in_resp = 0; txn = 0;
        if (e_res) fin = 1;
      end
      prev_w = m_write;
    end
  end

  // Bus responder personalities.
  initial forever begin
    @(posedge clk_i); #1;
    case (mode)
      0: begin m_waitrequest = 0; m_writeresponsevalid = 1; m_response = 2'b00; end
      1: begin
        m_waitrequest        = ($urandom_range(0, 2) == 0);
        m_writeresponsevalid = ($urandom_range(0, 4) > 1);
        m_response           = ($urandom_range(0, 9) == 0) ? 2'b10 : 2'b00;
      end
      2: begin m_waitrequest = 1; m_writeresponsevalid = 0; m_response = 2'b00; end
      3: begin m_waitrequest = 0; m_writeresponsevalid = 0; m_response = 2'b00; end
      default: begin m_waitrequest = 0; m_writeresponsevalid = 1; m_response = 2'b10; end
    endcase
  end

  task automatic cyc(input logic v, input logic [7:0] d, input logic dr, input logic [31:0] dc);
    @(posedge clk_i); #1;
    char_valid = v; char_data = d; done_req = dr; done_code = dc;
  endtask

  task automatic wait_idle(input int lim, input string name);
    int n;
    n = 0;
    repeat (2) @(negedge clk_i);
    while (!(q.size() == 0 && !txn && !pend && !exp_start) && n < lim) begin
      @(negedge clk_i); n++;
    end
    chk({name, "_drained"}, n < lim, 1);
  endtask

  task automatic pulse_reset();
    @(posedge clk_i); #1; rst_i = 1;
    repeat (2) @(posedge clk_i);
    #1; rst_i = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, k, n;
    char_valid = 0; char_data = 0; done_req = 0; done_code = 0;
    m_waitrequest = 0; m_writeresponsevalid = 0; m_response = 0;
    #2;
    chk("por_m_write", m_write, 0);
    chk("por_char_ready", char_ready, 0);
    repeat (3) @(posedge clk_i);
    #1; rst_i = 0;
    @(negedge clk_i);
    chk("ready_after_rst", char_ready, 1);

    // 'H','i' against a zero-wait responder.
    mode = 0;
    acc_addr.delete(); acc_data.delete(); acc_be.delete();
    cyc(1, 8'h48, 0, 0); cyc(1, 8'h69, 0, 0); cyc(0, 0, 0, 0);
    wait_idle(50, "hi");
    chk("hi_count", acc_data.size(), 2);
    if (acc_data.size() == 2) begin
      chk("hi_addr0", acc_addr[0], 32'hE000_FFF0);
      chk("hi_data0", acc_data[0], 32'h4800_0000);
      chk("hi_data1", acc_data[1], 32'h6900_0000);
      chk("hi_be1", acc_be[1], 4'b1000);
    end

    // Random traffic against a random responder.
    mode = 1;
    for (int i = 0; i < 3000; i++) cyc($urandom_range(0, 1) == 1, 8'($urandom), 0, 0);
    cyc(0, 0, 0, 0);
    mode = 0;
    wait_idle(300, "random");
    chk("random_busy", busy, 0);

    // Back-to-back pushes into a stalled bus.
    mode = 2;
    cyc(0, 0, 0, 0);
    s = npush;
    for (int i = 0; i < DEPTH + 4; i++) cyc(1, 8'(8'h30 + i), 0, 0);
    cyc(0, 0, 0, 0);
    @(negedge clk_i);
    chk("stall_pushes", npush - s, DEPTH + 1);
    chk("stall_ready", char_ready, 0);
    mode = 0;
    wait_idle(100, "stall");

    // Reset in the middle of a stalled write.
    mode = 2;
    cyc(1, 8'h55, 0, 0); cyc(0, 0, 0, 0);
    k = 0;
    while (!m_write && k < 10) begin @(negedge clk_i); k++; end
    chk("rst_mid_write_seen", m_write, 1);
    @(posedge clk_i); #2; rst_i = 1; #1;
    chk("rst_async_write", m_write, 0);
    chk("rst_async_addr", m_address, 0);
    chk("rst_async_data", m_writedata, 0);
    chk("rst_async_be", m_byteenable, 0);
    repeat (2) @(posedge clk_i);
    #1; rst_i = 0; mode = 0;
    @(negedge clk_i);
    chk("post_rst_flags", {busy, done, err_resp, err_timeout}, 0);
    chk("post_rst_ready", char_ready, 1);

    // Silent responder: the timeout fires four cycles into RESP.
    mode = 3;
    cyc(0, 0, 0, 0);
    cyc(1, 8'h58, 0, 0); cyc(0, 0, 0, 0);
    k = 0;
    while (!(m_write && !m_waitrequest) && k < 20) begin @(negedge clk_i); k++; end
    n = 0;
    while (!err_timeout && n < 20) begin @(negedge clk_i); n++; end
    chk("timeout_latency", n, 5);
    mode = 4;
    cyc(1, 8'h59, 0, 0); cyc(0, 0, 0, 0);
    wait_idle(50, "errresp");
    chk("err_resp_set", err_resp, 1);
    chk("err_timeout_sticky", err_timeout, 1);

    // Characters then a result; the second done request replaces the first code.
    pulse_reset();
    mode = 0;
    cyc(0, 0, 0, 0);
    acc_addr.delete(); acc_data.delete(); acc_be.delete();
    cyc(1, 8'h61, 1, 32'hDEAD_BEEF);
    cyc(1, 8'h62, 1, 32'h0000_0005);
    cyc(1, 8'h63, 0, 0);
    cyc(0, 0, 0, 0);
    n = 0;
    while (!done && n < 60) begin @(negedge clk_i); n++; end
    chk("result_done", done, 1);
    chk("result_count", acc_data.size(), 4);
    if (acc_data.size() == 4) begin
      chk("result_c0", acc_data[0], 32'h6100_0000);
      chk("result_c2", acc_data[2], 32'h6300_0000);
      chk("result_addr", acc_addr[3], 32'hE000_FFF8);
      chk("result_data", acc_data[3], 32'h0500_0000);
      chk("result_be", acc_be[3], 4'b1111);
    end

    // Terminal state: FIFO fills, nothing is sent, done_req ignored.
    s = npush;
    for (int i = 0; i < DEPTH + 2; i++) cyc(1, 8'(8'h70 + i), i == 0, 32'h1);
    cyc(0, 0, 0, 0);
    repeat (3) @(negedge clk_i);
    chk("fin_pushes", npush - s, DEPTH);
    chk("fin_ready", char_ready, 0);
    chk("fin_done", done, 1);
    chk("fin_busy", busy, 1);
    chk("fin_writes", acc_data.size(), 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
